mem_arbiter: RTL

Two-port arbiter sharing the single block-wide main memory between the instruction cache (read-only) and the data cache (read/write). Sits between both caches and main memory in the cache-enabled CPU top level. It latches one requester's command, drives the memory busywait handshake to completion, returns read data to the granted cache, and stalls the other requester via its busywait.

---
 rtl/mem_arbiter.sv | 231 +++++++++++++++++++++++
 1 files changed

// File: rtl/mem_arbiter.sv
// -----------------------------------------------------------------------------
// mem_arbiter
//
// Shares one block-wide main memory between the instruction cache (read-only)
// and the data cache (read/write). One requester's command is latched into the
// m_* registers, the memory busywait handshake is followed to completion, and
// the returned block is stored in the granted cache's readdata register. The
// other requester is held off through its busywait until it is served.
//
// Optional feature macro: MEM_ARB_RR_EN
//   defined   : round-robin between the ports when both request in IDLE
//               (last-grant register, reset value I, so D wins first).
//   undefined : fixed priority, data cache over instruction cache.
//
// Parameters
//   BLOCK_W : memory block width in bits
//   ADDR_W  : block address width
//
// Ports
//   CLK          in   system clock, rising edge
//   RESET        in   asynchronous active-low reset
//   i_read       in   instruction cache block-read request
//   i_address    in   instruction block address
//   i_readdata   out  block returned to the instruction cache (registered)
//   i_busywait   out  instruction requester stall (combinational)
//   d_read       in   data cache block-read request
//   d_write      in   data cache block-write request (wins over d_read)
//   d_address    in   data block address
//   d_writedata  in   write-back block
//   d_readdata   out  block returned to the data cache (registered)
//   d_busywait   out  data requester stall (combinational)
//   m_read       out  memory read command (registered)
//   m_write      out  memory write command (registered)
//   m_address    out  memory block address (registered)
//   m_writedata  out  memory write data (registered)
//   m_readdata   in   memory read data, valid when m_busywait falls
//   m_busywait   in   memory busy
// -----------------------------------------------------------------------------
module mem_arbiter #(
  parameter int BLOCK_W = 32,
  parameter int ADDR_W  = 6
) (
  input  logic               CLK,
  input  logic               RESET,
  input  logic               i_read,
  input  logic [ADDR_W-1:0]  i_address,
  output logic [BLOCK_W-1:0] i_readdata,
  output logic               i_busywait,
  input  logic               d_read,
  input  logic               d_write,
  input  logic [ADDR_W-1:0]  d_address,
  input  logic [BLOCK_W-1:0] d_writedata,
  output logic [BLOCK_W-1:0] d_readdata,
  output logic               d_busywait,
  output logic               m_read,
  output logic               m_write,
  output logic [ADDR_W-1:0]  m_address,
  output logic [BLOCK_W-1:0] m_writedata,
  input  logic [BLOCK_W-1:0] m_readdata,
  input  logic               m_busywait
);

  typedef enum logic [2:0] {
    ST_IDLE   = 3'd0,
    ST_I_ACC  = 3'd1,
    ST_D_ACC  = 3'd2,
    ST_I_DONE = 3'd3,
    ST_D_DONE = 3'd4
  } state_t;

  state_t state_r;
  state_t next_state_s;

  logic   seen_busy_r;
  logic   req_i_s;
  logic   req_d_s;
  logic   prefer_d_s;
  logic   load_i_s;
  logic   load_d_s;
  logic   finish_s;

  assign req_i_s = i_read;
  assign req_d_s = d_read | d_write;

`ifdef MEM_ARB_RR_EN
  // 1'b1 when the data port received the most recent grant.
  logic last_grant_d_r;

  // Last-grant tracking for round-robin arbitration.
  always_ff @(posedge CLK or negedge RESET) begin
    if (!RESET) begin
      last_grant_d_r <= 1'b0;
    end else if (load_d_s) begin
      last_grant_d_r <= 1'b1;
    end else if (load_i_s) begin
      last_grant_d_r <= 1'b0;
    end else begin
      last_grant_d_r <= last_grant_d_r;
    end
  end

  // Only consulted when both ports request; the port not served last wins.
  assign prefer_d_s = ~last_grant_d_r;
`else
  assign prefer_d_s = 1'b1;
`endif

  // State register.
  always_ff @(posedge CLK or negedge RESET) begin
    if (!RESET) begin
      state_r <= ST_IDLE;
    end else begin
      state_r <= next_state_s;
    end
  end

  // Next-state decode plus one-cycle strobes for the datapath registers.
  always_comb begin
    next_state_s = state_r;
    load_i_s     = 1'b0;
    load_d_s     = 1'b0;
    finish_s     = 1'b0;
    case (state_r)
      ST_IDLE: begin
        if (req_d_s && (!req_i_s || prefer_d_s)) begin
          load_d_s     = 1'b1;
          next_state_s = ST_D_ACC;
        end else if (req_i_s) begin
          load_i_s     = 1'b1;
          next_state_s = ST_I_ACC;
        end else begin
          next_state_s = ST_IDLE;
        end
      end
      ST_I_ACC: begin
        // Completion needs a busy phase first so a memory that has not yet
        // reacted to the command is not mistaken for a finished one.
        if (seen_busy_r && !m_busywait) begin
          finish_s     = 1'b1;
          next_state_s = ST_I_DONE;
        end else begin
          next_state_s = ST_I_ACC;
        end
      end
      ST_D_ACC: begin
        if (seen_busy_r && !m_busywait) begin
          finish_s     = 1'b1;
          next_state_s = ST_D_DONE;
        end else begin
          next_state_s = ST_D_ACC;
        end
      end
      ST_I_DONE: begin
        next_state_s = ST_IDLE;
      end
      ST_D_DONE: begin
        next_state_s = ST_IDLE;
      end
      default: begin
        next_state_s = ST_IDLE;
      end
    endcase
  end

  // Memory command registers: loaded on grant, cleared on completion.
  always_ff @(posedge CLK or negedge RESET) begin
    if (!RESET) begin
      m_read      <= 1'b0;
      m_write     <= 1'b0;
      m_address   <= {ADDR_W{1'b0}};
      m_writedata <= {BLOCK_W{1'b0}};
    end else if (load_d_s) begin
      // A simultaneous read and write is issued as the write.
      m_read      <= d_read & ~d_write;
      m_write     <= d_write;
      m_address   <= d_address;
      m_writedata <= d_writedata;
    end else if (load_i_s) begin
      m_read      <= 1'b1;
      m_write     <= 1'b0;
      m_address   <= i_address;
      m_writedata <= m_writedata;
    end else if (finish_s) begin
      m_read      <= 1'b0;
      m_write     <= 1'b0;
      m_address   <= m_address;
      m_writedata <= m_writedata;
    end else begin
      m_read      <= m_read;
      m_write     <= m_write;
      m_address   <= m_address;
      m_writedata <= m_writedata;
    end
  end

  // Readdata registers: captured only when a read completes, else held.
  always_ff @(posedge CLK or negedge RESET) begin
    if (!RESET) begin
      i_readdata <= {BLOCK_W{1'b0}};
      d_readdata <= {BLOCK_W{1'b0}};
    end else if (finish_s && m_read && (state_r == ST_I_ACC)) begin
      i_readdata <= m_readdata;
      d_readdata <= d_readdata;
    end else if (finish_s && m_read && (state_r == ST_D_ACC)) begin
      i_readdata <= i_readdata;
      d_readdata <= m_readdata;
    end else begin
      i_readdata <= i_readdata;
      d_readdata <= d_readdata;
    end
  end

  // Busy-phase flag: set on any access-state edge with memory busy.
  always_ff @(posedge CLK or negedge RESET) begin
    if (!RESET) begin
      seen_busy_r <= 1'b0;
    end else if (finish_s) begin
      seen_busy_r <= 1'b0;
    end else if (((state_r == ST_I_ACC) || (state_r == ST_D_ACC)) && m_busywait) begin
      seen_busy_r <= 1'b1;
    end else begin
      seen_busy_r <= seen_busy_r;
    end
  end

  // A requester is released only in its own DONE cycle; both stalls are
  // forced low while reset is asserted.
  assign i_busywait = RESET & req_i_s & (state_r != ST_I_DONE);
  assign d_busywait = RESET & req_d_s & (state_r != ST_D_DONE);

endmodule
